// File: rtl/avl_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// avl_mem_arbiter_if
// Bundles the host-side request ports and the Avalon memory-side signals of
// avl_mem_arbiter.
//   master : the arbiter's view (drives host_ready/host_rdata*, avl_* requests)
//   slave  : the environment's view (drives host requests and memory returns)
// Port i of every packed host vector lives at slice i.
// ---------------------------------------------------------------------------
interface avl_mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 64
);
    // host side
    logic [NUM_PORTS-1:0]                  host_read_req;
    logic [NUM_PORTS-1:0]                  host_write_req;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]       host_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0]       host_wdata;
    logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   host_be;
    logic [NUM_PORTS-1:0]                  host_ready;
    logic [NUM_PORTS-1:0]                  host_rdata_valid;
    logic [DATA_WIDTH-1:0]                 host_rdata;

    // memory side
    logic                                  avl_ready;
    logic                                  avl_read_req;
    logic                                  avl_write_req;
    logic                                  avl_burstbegin;
    logic [ADDR_WIDTH-1:0]                 avl_addr;
    logic [DATA_WIDTH-1:0]                 avl_wdata;
    logic [DATA_WIDTH/8-1:0]               avl_be;
    logic [6:0]                            avl_size;
    logic                                  avl_rdata_valid;
    logic [DATA_WIDTH-1:0]                 avl_rdata;

    modport master (
        input  host_read_req, host_write_req, host_addr, host_wdata, host_be,
        output host_ready, host_rdata_valid, host_rdata,
        input  avl_ready, avl_rdata_valid, avl_rdata,
        output avl_read_req, avl_write_req, avl_burstbegin, avl_addr,
               avl_wdata, avl_be, avl_size
    );

    modport slave (
        output host_read_req, host_write_req, host_addr, host_wdata, host_be,
        input  host_ready, host_rdata_valid, host_rdata,
        output avl_ready, avl_rdata_valid, avl_rdata,
        input  avl_read_req, avl_write_req, avl_burstbegin, avl_addr,
               avl_wdata, avl_be, avl_size
    );
endinterface

// File: rtl/avl_mem_arbiter.sv
// ---------------------------------------------------------------------------
// avl_mem_arbiter
// Round-robin arbiter sharing one Avalon memory port among NUM_PORTS hosts.
// One request register feeds the memory; read returns (in request order) are
// routed back to their host through an ID FIFO of depth MAX_OUTSTANDING.
//
// Ports:
//   clk, reset            sole clock, synchronous active-high reset
//   bus (master modport)  host request/response and Avalon signals
//   err_unexpected_rdata  sticky error flag, only when
//                         AVL_MEM_ARBITER_ERR_CHECK_EN is defined
//
// Optional build macro: AVL_MEM_ARBITER_ERR_CHECK_EN
//   Adds err_unexpected_rdata, set on a memory return with no outstanding
//   read or on a host driving read and write together; cleared by reset.
// ---------------------------------------------------------------------------
module avl_mem_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_WIDTH      = 24,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic clk,
    input  logic reset,
`ifdef AVL_MEM_ARBITER_ERR_CHECK_EN
    output logic err_unexpected_rdata,
`endif
    avl_mem_arbiter_if.master bus
);

    localparam int BEW = DATA_WIDTH / 8;
    localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW  = IDW + 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NUM_PORTS - 1);

    // wrap-around increment for FIFO pointers
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    logic                  stage_valid_r;
    logic                  stage_write_r;
    logic [ADDR_WIDTH-1:0] stage_addr_r;
    logic [DATA_WIDTH-1:0] stage_wdata_r;
    logic [BEW-1:0]        stage_be_r;
    logic [IDW-1:0]        last_grant_r;
    logic [IDW-1:0]        fifo_mem_r [MAX_OUTSTANDING];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;

    logic                  load_ok_s;
    logic                  read_ok_s;
    logic [NUM_PORTS-1:0]  eligible_s;
    logic                  grant_found_s;
    logic [IDW-1:0]        grant_idx_s;
    logic [SW-1:0]         cand_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;

    assign load_ok_s  = !stage_valid_r || bus.avl_ready;
    assign read_ok_s  = (count_r < CW'(MAX_OUTSTANDING));
    // a full ID FIFO masks reads only; writes stay eligible
    assign eligible_s = bus.host_write_req | (bus.host_read_req & {NUM_PORTS{read_ok_s}});
    assign accept_s   = grant_found_s && load_ok_s && !reset;
    assign push_s     = accept_s && bus.host_read_req[grant_idx_s];
    // returns with nothing outstanding are dropped
    assign pop_s      = bus.avl_rdata_valid && (count_r != '0) && !reset;

    // round-robin search starting one past the last granted port
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_s = {1'b0, last_grant_r} + SW'(k + 1);
            cand_s = (cand_s >= SW'(NUM_PORTS)) ? (cand_s - SW'(NUM_PORTS)) : cand_s;
            if (!grant_found_s && eligible_s[cand_s[IDW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[IDW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // one-hot accept strobe towards the granted host
    always_comb begin
        bus.host_ready = '0;
        if (accept_s) begin
            bus.host_ready[grant_idx_s] = 1'b1;
        end else begin
            bus.host_ready = '0;
        end
    end

    // route a memory return to the host at the head of the ID FIFO
    always_comb begin
        bus.host_rdata_valid = '0;
        if (pop_s) begin
            bus.host_rdata_valid[fifo_mem_r[rd_ptr_r]] = 1'b1;
        end else begin
            bus.host_rdata_valid = '0;
        end
    end

    assign bus.host_rdata = bus.avl_rdata;

    // output request stage; holds while the memory stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_r <= 1'b0;
            stage_write_r <= 1'b0;
            stage_addr_r  <= '0;
            stage_wdata_r <= '0;
            stage_be_r    <= '0;
        end else if (load_ok_s) begin
            stage_valid_r <= accept_s;
            if (accept_s) begin
                stage_write_r <= bus.host_write_req[grant_idx_s];
                stage_addr_r  <= bus.host_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                stage_wdata_r <= bus.host_wdata[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                stage_be_r    <= bus.host_be[grant_idx_s*BEW +: BEW];
            end else begin
                stage_write_r <= stage_write_r;
            end
        end else begin
            stage_valid_r <= stage_valid_r;
        end
    end

    // request outputs are masked while reset is asserted
    assign bus.avl_read_req   = stage_valid_r && !stage_write_r && !reset;
    assign bus.avl_write_req  = stage_valid_r &&  stage_write_r && !reset;
    assign bus.avl_burstbegin = stage_valid_r && !reset;
    assign bus.avl_addr       = stage_addr_r;
    assign bus.avl_wdata      = stage_wdata_r;
    assign bus.avl_be         = stage_be_r;
    assign bus.avl_size       = 7'd1;

    // round-robin pointer, moves only on an accept
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= LAST_INIT;
        end else if (accept_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // ID FIFO storage; contents are meaningless once pointers reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= grant_idx_s;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // ID FIFO pointers and outstanding-read count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= push_s ? next_ptr(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? next_ptr(rd_ptr_r) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef AVL_MEM_ARBITER_ERR_CHECK_EN
    logic err_r;

    // sticky protocol-error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if ((bus.avl_rdata_valid && (count_r == '0)) ||
                     (|(bus.host_read_req & bus.host_write_req))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_unexpected_rdata = err_r;
`endif

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// Directed self-checking bench for avl_mem_arbiter (2-port and 4-port builds).
module tb_avl_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    avl_mem_arbiter_if #(.NUM_PORTS(2)) b2 ();
    avl_mem_arbiter_if #(.NUM_PORTS(4)) b4 ();

`ifdef AVL_MEM_ARBITER_ERR_CHECK_EN
    logic err2;
    logic err4;
`endif

    avl_mem_arbiter #(.NUM_PORTS(2)) d2 (
        .clk(clk),
        .reset(reset),
`ifdef AVL_MEM_ARBITER_ERR_CHECK_EN
        .err_unexpected_rdata(err2),
`endif
        .bus(b2)
    );

    avl_mem_arbiter #(.NUM_PORTS(4)) d4 (
        .clk(clk),
        .reset(reset),
`ifdef AVL_MEM_ARBITER_ERR_CHECK_EN
        .err_unexpected_rdata(err4),
`endif
        .bus(b4)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b2.host_read_req = '0; b2.host_write_req = '0; b2.host_addr = '0;
        b2.host_wdata = '0; b2.host_be = '0; b2.avl_ready = 1'b1;
        b2.avl_rdata_valid = 1'b0; b2.avl_rdata = '0;
        b4.host_read_req = '0; b4.host_write_req = '0; b4.host_addr = '0;
        b4.host_wdata = '0; b4.host_be = '0; b4.avl_ready = 1'b1;
        b4.avl_rdata_valid = 1'b0; b4.avl_rdata = '0;

        // reset: requests and a return must all be suppressed
        reset = 1'b1;
        b2.host_read_req = 2'b11;
        b2.avl_rdata_valid = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_ready",  64'(b2.host_ready), 64'h0);
        chk("rst_rvalid", 64'(b2.host_rdata_valid), 64'h0);
        chk("rst_avl_rd", 64'(b2.avl_read_req), 64'h0);
        chk("rst_burst",  64'(b2.avl_burstbegin), 64'h0);
        tick();
        reset = 1'b0;
        b2.host_read_req = 2'b00;
        b2.avl_rdata_valid = 1'b0;

        // two ports reading continuously: grants 0,1,0,1
        b2.host_addr = {24'h000200, 24'h000100};
        b2.host_read_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready", 64'(b2.host_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) begin
                chk("rr_avl_rd", 64'(b2.avl_read_req), 64'h1);
                chk("rr_addr", 64'(b2.avl_addr), (i % 2 == 1) ? 64'h100 : 64'h200);
            end
            tick();
        end
        b2.host_read_req = 2'b00;
        @(negedge clk);
        chk("rr_last_rd", 64'(b2.avl_read_req), 64'h1);
        chk("rr_last_addr", 64'(b2.avl_addr), 64'h200);
        chk("rr_size", 64'(b2.avl_size), 64'h1);
        chk("rr_burst", 64'(b2.avl_burstbegin), 64'h1);
        chk("rr_idle_ready", 64'(b2.host_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("rr_stage_empty", 64'(b2.avl_read_req), 64'h0);
        tick();

        // returns come back in order 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            b2.avl_rdata_valid = 1'b1;
            b2.avl_rdata = 64'hA000 + 64'(i);
            @(negedge clk);
            chk("ret_valid", 64'(b2.host_rdata_valid), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("ret_data", 64'(b2.host_rdata), 64'hA000 + 64'(i));
            tick();
        end

        // extra return with nothing outstanding is ignored
        @(negedge clk);
        chk("empty_ret", 64'(b2.host_rdata_valid), 64'h0);
        tick();
        b2.avl_rdata_valid = 1'b0;
`ifdef AVL_MEM_ARBITER_ERR_CHECK_EN
        @(negedge clk);
        chk("err_empty", 64'(err2), 64'h1);
        tick();
`endif

        // port 1 fills the ID FIFO with 16 reads
        b2.host_read_req = 2'b10;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("fill_ready", 64'(b2.host_ready), 64'h2);
            tick();
        end
        @(negedge clk);
        chk("full_hold", 64'(b2.host_ready), 64'h0);
        tick();
        b2.host_write_req = 2'b01;
        b2.host_addr[23:0] = 24'h000333;
        b2.host_wdata[63:0] = 64'h5555;
        b2.host_be[7:0] = 8'hF0;
        @(negedge clk);
        chk("full_wr_grant", 64'(b2.host_ready), 64'h1);
        tick();
        b2.host_write_req = 2'b00;
        @(negedge clk);
        chk("full_wr_req", 64'(b2.avl_write_req), 64'h1);
        chk("full_wr_addr", 64'(b2.avl_addr), 64'h333);
        chk("full_wr_be", 64'(b2.avl_be), 64'hF0);
        chk("full_rd_masked", 64'(b2.host_ready), 64'h0);
        tick();
        b2.avl_rdata_valid = 1'b1;
        b2.avl_rdata = 64'hBEEF;
        @(negedge clk);
        chk("full_ret_valid", 64'(b2.host_rdata_valid), 64'h2);
        chk("full_ret_hold", 64'(b2.host_ready), 64'h0);
        tick();
        b2.avl_rdata_valid = 1'b0;
        @(negedge clk);
        chk("full_reenable", 64'(b2.host_ready), 64'h2);
        tick();
        b2.host_read_req = 2'b00;
        b2.avl_rdata_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("drain_valid", 64'(b2.host_rdata_valid), 64'h2);
            tick();
        end
        b2.avl_rdata_valid = 1'b0;

        // memory stall with a write in the stage
        b2.avl_ready = 1'b0;
        b2.host_write_req = 2'b10;
        b2.host_addr[47:24] = 24'h0ABCDE;
        b2.host_wdata[127:64] = 64'h1122334455667788;
        b2.host_be[15:8] = 8'h5A;
        @(negedge clk);
        chk("stall_load", 64'(b2.host_ready), 64'h2);
        tick();
        b2.host_write_req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", 64'(b2.host_ready), 64'h0);
            chk("stall_wr", 64'(b2.avl_write_req), 64'h1);
            chk("stall_addr", 64'(b2.avl_addr), 64'h0ABCDE);
            chk("stall_wdata", 64'(b2.avl_wdata), 64'h1122334455667788);
            chk("stall_be", 64'(b2.avl_be), 64'h5A);
            tick();
        end
        b2.avl_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", 64'(b2.host_ready), 64'h1);
        tick();
        b2.host_write_req = 2'b00;
        @(negedge clk);
        chk("post_stall_addr", 64'(b2.avl_addr), 64'h333);
        chk("post_stall_wr", 64'(b2.avl_write_req), 64'h1);
        tick();
        @(negedge clk);
        chk("post_stall_idle", 64'(b2.avl_write_req), 64'h0);
        tick();

        // read accept coinciding with a pop keeps the count
        b2.host_read_req = 2'b01;
        @(negedge clk);
        chk("pp_first", 64'(b2.host_ready), 64'h1);
        tick();
        b2.host_read_req = 2'b10;
        b2.avl_rdata_valid = 1'b1;
        b2.avl_rdata = 64'hC0;
        @(negedge clk);
        chk("pp_ready", 64'(b2.host_ready), 64'h2);
        chk("pp_pop_id", 64'(b2.host_rdata_valid), 64'h1);
        tick();
        b2.host_read_req = 2'b00;
        b2.avl_rdata = 64'hC1;
        @(negedge clk);
        chk("pp_second_id", 64'(b2.host_rdata_valid), 64'h2);
        chk("pp_second_data", 64'(b2.host_rdata), 64'hC1);
        tick();
        @(negedge clk);
        chk("pp_now_empty", 64'(b2.host_rdata_valid), 64'h0);
        tick();
        b2.avl_rdata_valid = 1'b0;

        // reset with three reads outstanding drops them
        b2.host_read_req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pre_rst_ready", 64'(b2.host_ready), 64'h1);
            tick();
        end
        b2.host_read_req = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rd", 64'(b2.avl_read_req), 64'h0);
        chk("mid_rst_burst", 64'(b2.avl_burstbegin), 64'h0);
        tick();
        reset = 1'b0;
        b2.avl_rdata_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_rd", 64'(b2.avl_read_req), 64'h0);
        chk("post_rst_rvalid", 64'(b2.host_rdata_valid), 64'h0);
`ifdef AVL_MEM_ARBITER_ERR_CHECK_EN
        chk("err_cleared", 64'(err2), 64'h0);
`endif
        tick();
        b2.avl_rdata_valid = 1'b0;
`ifdef AVL_MEM_ARBITER_ERR_CHECK_EN
        @(negedge clk);
        chk("err_after_rst", 64'(err2), 64'h1);
        tick();
`endif

        // four ports requesting continuously: strict rotation
        b4.host_write_req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr4_ready", 64'(b4.host_ready), 64'h1 << (k % 4));
            tick();
        end
        b4.host_write_req = 4'h0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avl_mem_arbiter.md
AVL_MEM_ARBITER -- requirements
Module: avl_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of host Avalon ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 24: word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: data width; byte-enable width = DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 16: read-return ID FIFO depth (power of 2).
REQ-005 SHALL use one clock and a synchronous, active-high reset: ports clk and reset.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 host_read_req, host_write_req  input  NUM_PORTS  per-port request; never both set on one port.
REQ-009 host_addr  input  NUM_PORTS*ADDR_WIDTH; host_wdata  input  NUM_PORTS*DATA_WIDTH; host_be  input  NUM_PORTS*DATA_WIDTH/8; port i at slice i.
REQ-010 host_ready  output  NUM_PORTS  per-port accept; a request transfers when req and ready are both high.
REQ-011 host_rdata_valid  output  NUM_PORTS; host_rdata  output  DATA_WIDTH, shared by all ports.
REQ-012 avl_ready  input  1; avl_read_req, avl_write_req, avl_burstbegin  output  1; avl_addr  output  ADDR_WIDTH; avl_wdata  output  DATA_WIDTH; avl_be  output  DATA_WIDTH/8; avl_size  output  7.
REQ-013 avl_rdata_valid  input  1; avl_rdata  input  DATA_WIDTH: memory read return, in request order.

Function
REQ-014 Output stage SHALL be one register (valid, op, addr, wdata, be), loadable when !valid or avl_ready.
REQ-015 Grant SHALL be round-robin: search starts at port (last_grant+1) mod NUM_PORTS; the first requesting eligible port wins.
REQ-016 Eligible SHALL mean write request, or read request with outstanding count < MAX_OUTSTANDING.
REQ-017 host_ready[i] SHALL be high only for the granted port, only when the output stage is loadable; at most one bit high per cycle.
REQ-018 Accept SHALL load the output stage the same edge; avl_*_req asserted the following cycle (request latency 1).
REQ-019 avl_read_req/avl_write_req SHALL equal stage valid and op; avl_burstbegin SHALL equal stage valid; avl_size SHALL be constant 1.
REQ-020 Stage SHALL hold all avl_* outputs stable while valid and avl_ready low.
REQ-021 last_grant SHALL update only on an accept.
REQ-022 A read accept SHALL push the port index into the ID FIFO and increment the outstanding count.
REQ-023 avl_rdata_valid SHALL pop the FIFO and assert host_rdata_valid[popped id] combinationally the same cycle, with host_rdata = avl_rdata.
REQ-024 Simultaneous push and pop SHALL leave the count unchanged; the count SHALL never exceed MAX_OUTSTANDING.
REQ-025 Writes SHALL still be granted while the FIFO is full; full only masks reads.
REQ-026 avl_rdata_valid with an empty FIFO SHALL be ignored: no pop, no host_rdata_valid.

Reset
REQ-027 Reset SHALL clear stage valid, the FIFO and the outstanding count, and set last_grant = NUM_PORTS-1 so port 0 has first priority.
REQ-028 During reset, host_ready, host_rdata_valid, avl_read_req, avl_write_req and avl_burstbegin SHALL be 0.
REQ-029 Reset mid-operation SHALL drop the stage request and all outstanding read IDs; later returns fall under REQ-026.

Configuration
REQ-030 Macro AVL_MEM_ARBITER_ERR_CHECK_EN defined: the block SHALL add output err_unexpected_rdata (1 bit), set sticky on a REQ-026 event or a host port asserting read and write together, and cleared only by reset.
REQ-031 Macro AVL_MEM_ARBITER_ERR_CHECK_EN undefined: the err_unexpected_rdata port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Ports 0 and 1 both hold reads, avl_ready=1 -> grant order 0,1,0,1; each port's data returns only on its own host_rdata_valid bit.
REQ-033 Port 1 issues 16 reads, memory returns none -> 17th read is held (host_ready[1]=0) while a port 0 write is granted; one return then re-enables reads.
REQ-034 avl_ready held low 5 cycles with a write in the stage -> avl_addr, avl_wdata and avl_be are unchanged for all 5 cycles; no host_ready.
REQ-035 Read accepted the same cycle avl_rdata_valid pops -> count unchanged; returned id matches the earliest outstanding read.
REQ-036 Reset asserted with 3 reads outstanding, then 1 avl_rdata_valid -> no host_rdata_valid; with the macro defined, err_unexpected_rdata=1.
REQ-037 NUM_PORTS=4, all ports request continuously -> each port is granted exactly once in every 4 accepts.
